// File: rtl/quad_corner_adjust.sv
// Keystone corner store: button-driven corner select, step/repeat moves,
// and clamping of every corner to the 640x480 frame.
module quad_corner_adjust #(
    parameter int STEP          = 1,
    parameter int REPEAT_DELAY  = 16_250_000,
    parameter int REPEAT_PERIOD = 1_625_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [9:0] x1,
    output logic [9:0] x2,
    output logic [9:0] x3,
    output logic [9:0] x4,
    output logic [8:0] y1,
    output logic [8:0] y2,
    output logic [8:0] y3,
    output logic [8:0] y4,
    output logic [1:0] sel_corner,
    output logic       changed
);

    localparam int CMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HOLD = 2'd1;
    localparam logic [1:0] S_REP  = 2'd2;

    localparam logic signed [10:0] STP   = 11'(STEP);
    localparam logic signed [10:0] X_MAX = 11'sd639;
    localparam logic signed [10:0] Y_MAX = 11'sd479;

    logic [9:0]    xs [4];
    logic [8:0]    ys [4];
    logic [1:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    dir, prev_dir;
    logic          sel_q, sel_rise, move;
    logic [9:0]    cur_x, nx;
    logic [8:0]    cur_y, ny;
    logic signed [10:0] tx, ty;

    assign dir      = {btn_up, btn_down, btn_left, btn_right};
    assign sel_rise = btn_sel & ~sel_q;
    assign cur_x    = xs[sel_corner];
    assign cur_y    = ys[sel_corner];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        move     = 1'b0;
        case (state)
            S_IDLE: begin
                if (dir != 4'd0) begin
                    move     = 1'b1;
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                end
            end
            S_HOLD: begin
                if (dir == 4'd0) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (dir != prev_dir) begin
                    move   = 1'b1;
                    cnt_nx = '0;
                end else if (cnt == CW'(REPEAT_DELAY - 1)) begin
                    move     = 1'b1;
                    state_nx = S_REP;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            S_REP: begin
                if (dir == 4'd0) begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end else if (dir != prev_dir) begin
                    move     = 1'b1;
                    state_nx = S_HOLD;
                    cnt_nx   = '0;
                end else if (cnt == CW'(REPEAT_PERIOD - 1)) begin
                    move   = 1'b1;
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Opposing buttons cancel on their axis; signed math keeps underflow visible.
    always_comb begin
        tx = signed'({1'b0, cur_x});
        ty = signed'({2'b00, cur_y});
        if (dir[0] && !dir[1]) tx = tx + STP;
        if (dir[1] && !dir[0]) tx = tx - STP;
        if (dir[2] && !dir[3]) ty = ty + STP;
        if (dir[3] && !dir[2]) ty = ty - STP;
        nx = (tx < 0) ? 10'd0 : (tx > X_MAX) ? 10'd639 : tx[9:0];
        ny = (ty < 0) ? 9'd0  : (ty > Y_MAX) ? 9'd479  : ty[8:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xs[0]      <= 10'd0;
            xs[1]      <= 10'd639;
            xs[2]      <= 10'd639;
            xs[3]      <= 10'd0;
            ys[0]      <= 9'd0;
            ys[1]      <= 9'd0;
            ys[2]      <= 9'd479;
            ys[3]      <= 9'd479;
            sel_corner <= 2'd0;
            changed    <= 1'b0;
            state      <= S_IDLE;
            cnt        <= '0;
            prev_dir   <= 4'd0;
            sel_q      <= 1'b0;
        end else begin
            sel_q   <= btn_sel;
            changed <= 1'b0;
            if (!enable) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                state    <= state_nx;
                cnt      <= cnt_nx;
                prev_dir <= dir;
                if (sel_rise) begin
                    sel_corner <= sel_corner + 2'd1;
                end else if (move && (nx != cur_x || ny != cur_y)) begin
                    xs[sel_corner] <= nx;
                    ys[sel_corner] <= ny;
                    changed        <= 1'b1;
                end
            end
        end
    end

    assign x1 = xs[0];
    assign x2 = xs[1];
    assign x3 = xs[2];
    assign x4 = xs[3];
    assign y1 = ys[0];
    assign y2 = ys[1];
    assign y3 = ys[2];
    assign y4 = ys[3];

endmodule

// File: tb/tb_quad_corner_adjust.sv
// Directed vector table plus randomized run against a press-age model.
module tb_quad_corner_adjust;

    localparam int STEP = 5;
    localparam int RD   = 4;
    localparam int RP   = 2;

    localparam logic [3:0] U = 4'b1000;
    localparam logic [3:0] D = 4'b0100;
    localparam logic [3:0] L = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    logic clk = 1'b0;
    logic reset, enable;
    logic btn_up, btn_down, btn_left, btn_right, btn_sel;
    logic [9:0] x1, x2, x3, x4;
    logic [8:0] y1, y2, y3, y4;
    logic [1:0] sel_corner;
    logic       changed;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    quad_corner_adjust #(
        .STEP(STEP), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .btn_sel(btn_sel),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .y1(y1), .y2(y2), .y3(y3), .y4(y4),
        .sel_corner(sel_corner), .changed(changed)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       sel;
        logic [3:0] dir;
        int         ci;
        int         ex;
        int         ey;
        int         es;
        int         ec;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rst, input logic en,
                                input logic sel, input logic [3:0] dir,
                                input int ci, input int ex, input int ey,
                                input int es, input int ec);
        vec_t v;
        v.rst = rst; v.en = en; v.sel = sel; v.dir = dir;
        v.ci = ci; v.ex = ex; v.ey = ey; v.es = es; v.ec = ec;
        vq.push_back(v);
    endfunction

    function automatic int dut_x(input int i);
        case (i)
            0: return int'(x1);
            1: return int'(x2);
            2: return int'(x3);
            default: return int'(x4);
        endcase
    endfunction

    function automatic int dut_y(input int i);
        case (i)
            0: return int'(y1);
            1: return int'(y2);
            2: return int'(y3);
            default: return int'(y4);
        endcase
    endfunction

    task automatic check(input string name, input int idx,
                         input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0d: got %0d, expected %0d",
                     name, idx, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic en,
                         input logic sel, input logic [3:0] dir);
        reset     = rst;
        enable    = en;
        btn_sel   = sel;
        btn_up    = dir[3];
        btn_down  = dir[2];
        btn_left  = dir[1];
        btn_right = dir[0];
        @(posedge clk);
        #1;
    endtask

    // Reference model: moves are decided by how long the same direction
    // has been held, not by any state machine.
    int         mx[4], my[4];
    int         msel, mch, age;
    logic [3:0] pdir;
    logic       shist;

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic void model_step(input logic rst, input logic en,
                                       input logic sel,
                                       input logic [3:0] dir);
        logic rise, mv;
        int   nxv, nyv;
        if (rst) begin
            mx[0] = 0;   my[0] = 0;
            mx[1] = 639; my[1] = 0;
            mx[2] = 639; my[2] = 479;
            mx[3] = 0;   my[3] = 479;
            msel = 0; mch = 0; age = 0; pdir = 4'd0; shist = 1'b0;
            return;
        end
        mch   = 0;
        rise  = sel & ~shist;
        shist = sel;
        if (!en) begin
            pdir = 4'd0;
            return;
        end
        mv = 1'b0;
        if (dir == 4'd0) begin
            pdir = 4'd0;
        end else begin
            if (dir != pdir) age = 0;
            else age++;
            pdir = dir;
            mv = (age == 0) || (age == RD) ||
                 (age > RD && ((age - RD) % RP) == 0);
        end
        if (rise) begin
            msel = (msel + 1) % 4;
        end else if (mv) begin
            nxv = mx[msel];
            nyv = my[msel];
            if (dir[0] && !dir[1]) nxv += STEP;
            if (dir[1] && !dir[0]) nxv -= STEP;
            if (dir[2] && !dir[3]) nyv += STEP;
            if (dir[3] && !dir[2]) nyv -= STEP;
            nxv = clampi(nxv, 639);
            nyv = clampi(nyv, 479);
            if (nxv != mx[msel] || nyv != my[msel]) begin
                mx[msel] = nxv;
                my[msel] = nyv;
                mch = 1;
            end
        end
    endfunction

    initial begin
        logic [3:0] rdir;
        logic       ren, rsel, rrst;

        // reset
        add(1,1,0,0, 0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0);
        add(0,1,0,0, 1,639,0,0,0);
        add(0,1,0,0, 2,639,479,0,0);
        add(0,1,0,0, 3,0,479,0,0);
        // single moves
        add(0,1,0,R, 0,5,0,0,1);
        add(0,1,0,D, 0,5,5,0,1);
        add(0,1,0,0, 0,5,5,0,0);
        // select corner 2, hold left 12 cycles
        add(0,1,1,0, 1,639,0,1,0);
        add(0,1,0,0, 1,639,0,1,0);
        add(0,1,0,L, 1,634,0,1,1);
        add(0,1,0,L, 1,634,0,1,0);
        add(0,1,0,L, 1,634,0,1,0);
        add(0,1,0,L, 1,634,0,1,0);
        add(0,1,0,L, 1,629,0,1,1);
        add(0,1,0,L, 1,629,0,1,0);
        add(0,1,0,L, 1,624,0,1,1);
        add(0,1,0,L, 1,624,0,1,0);
        add(0,1,0,L, 1,619,0,1,1);
        add(0,1,0,L, 1,619,0,1,0);
        add(0,1,0,L, 1,614,0,1,1);
        add(0,1,0,L, 1,614,0,1,0);
        add(0,1,0,0, 1,614,0,1,0);
        add(0,1,0,0, 1,614,0,1,0);
        // back to corner 1 (wraps 3 -> 0)
        add(0,1,1,0, 0,5,5,2,0);
        add(0,1,0,0, 0,5,5,2,0);
        add(0,1,1,0, 0,5,5,3,0);
        add(0,1,0,0, 0,5,5,3,0);
        add(0,1,1,0, 0,5,5,0,0);
        add(0,1,0,0, 0,5,5,0,0);
        // up+left to the corner, then clamp
        add(0,1,0,U|L, 0,0,0,0,1);
        add(0,1,0,0, 0,0,0,0,0);
        add(0,1,0,U|L, 0,0,0,0,0);
        add(0,1,0,0, 0,0,0,0,0);
        // four selects: 1,2,3,0
        for (int i = 1; i <= 4; i++) begin
            add(0,1,1,0, 0,0,0,i % 4,0);
            add(0,1,0,0, 0,0,0,i % 4,0);
        end
        // select and right together: select wins, repeat after delay
        add(0,1,1,R, 1,614,0,1,0);
        add(0,1,0,R, 0,0,0,1,0);
        add(0,1,0,R, 1,614,0,1,0);
        add(0,1,0,R, 1,614,0,1,0);
        add(0,1,0,R, 1,619,0,1,1);
        add(0,1,0,0, 1,619,0,1,0);
        // disabled while holding right
        for (int i = 0; i < 10; i++) add(0,0,0,R, 1,619,0,1,0);
        add(0,1,0,R, 1,624,0,1,1);
        add(0,1,0,R, 1,624,0,1,0);
        add(0,1,0,R, 1,624,0,1,0);
        add(0,1,0,R, 1,624,0,1,0);
        add(0,1,0,R, 1,629,0,1,1);
        add(0,1,0,R, 1,629,0,1,0);
        add(0,1,0,R, 1,634,0,1,1);
        // reset mid-repeat, button still held
        add(1,1,0,R, 1,639,0,0,0);
        add(0,1,0,R, 0,5,0,0,1);
        add(0,1,0,0, 0,5,0,0,0);
        // selects ignored while disabled; history still tracked
        add(0,0,1,0, 0,5,0,0,0);
        add(0,1,1,0, 0,5,0,0,0);
        add(0,1,0,0, 0,5,0,0,0);
        // btn_sel held through reset gives one select edge
        add(1,1,1,0, 0,0,0,0,0);
        add(0,1,1,0, 0,0,0,1,0);
        add(0,1,1,0, 0,0,0,1,0);
        add(0,1,0,0, 0,0,0,1,0);

        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].en, vq[i].sel, vq[i].dir);
            check("sel", i, int'(sel_corner), vq[i].es);
            check("changed", i, int'(changed), vq[i].ec);
            check("x", i, dut_x(vq[i].ci), vq[i].ex);
            check("y", i, dut_y(vq[i].ci), vq[i].ey);
        end

        // randomized run against the model
        model_step(1'b1, 1'b1, 1'b0, 4'd0);
        apply(1'b1, 1'b1, 1'b0, 4'd0);
        rdir = 4'd0;
        rsel = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) rdir = 4'($urandom_range(15));
            if ($urandom_range(5) == 0) rsel = ~rsel;
            ren  = ($urandom_range(19) != 0);
            rrst = ($urandom_range(299) == 0);
            model_step(rrst, ren, rsel, rdir);
            apply(rrst, ren, rsel, rdir);
            check("rnd_sel", c, int'(sel_corner), msel);
            check("rnd_changed", c, int'(changed), mch);
            for (int k = 0; k < 4; k++) begin
                check("rnd_x", c, dut_x(k), mx[k]);
                check("rnd_y", c, dut_y(k), my[k]);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
